// File: rtl/muxn_reg.sv
// N-channel registered multiplexer with valid/ready on every input and on the output.
// The source channel comes from the sel port or from a round-robin arbiter, chosen at run time.
module muxn_reg #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SELW-1:0]    out_chan
);

  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic [SELW-1:0]  out_chan_r;
  logic [SELW-1:0]  rr_last_r;

  logic             load_en_s;
  logic             ext_found_s;
  logic [SELW-1:0]  ext_idx_s;
  logic             rr_found_s;
  logic [SELW-1:0]  rr_idx_s;
  logic             grant_valid_s;
  logic [SELW-1:0]  grant_idx_s;
  logic [N-1:0]     grant_oh_s;
  logic [N-1:0]     in_ready_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             xfer_s;

  // External-select candidate: sel values of N or above never match any channel.
  always_comb begin
    ext_found_s = 1'b0;
    ext_idx_s   = {SELW{1'b0}};
    for (int i = 0; i < N; i++) begin
      ext_found_s = ext_found_s | (in_valid[i] && (int'(sel) == i));
      ext_idx_s   = (in_valid[i] && (int'(sel) == i)) ? SELW'(i) : ext_idx_s;
    end
  end

  // Round-robin candidate: distance k runs downward so the nearest valid channel after rr_last wins.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {SELW{1'b0}};
    for (int k = N; k >= 1; k--) begin
      for (int i = 0; i < N; i++) begin
        rr_found_s = rr_found_s | (in_valid[i] && (((int'(rr_last_r) + k) % N) == i));
        rr_idx_s   = (in_valid[i] && (((int'(rr_last_r) + k) % N) == i)) ? SELW'(i) : rr_idx_s;
      end
    end
  end

  // Grant, ready and data steering; a stalled output register blocks every grant.
  always_comb begin
    load_en_s     = !out_valid_r || out_ready;
    grant_valid_s = mode ? rr_found_s : ext_found_s;
    grant_idx_s   = mode ? rr_idx_s : ext_idx_s;
    sel_data_s    = {WIDTH{1'b0}};
    for (int i = 0; i < N; i++) begin
      grant_oh_s[i] = grant_valid_s && (grant_idx_s == SELW'(i));
      in_ready_s[i] = grant_oh_s[i] && load_en_s && !rst;
      sel_data_s    = sel_data_s | (grant_oh_s[i] ? in_data[i*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
    xfer_s = |in_ready_s;
  end

  // Output register and round-robin pointer; a take without a new load leaves data/chan stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_r  <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      out_chan_r  <= {SELW{1'b0}};
      rr_last_r   <= SELW'(N - 1);
    end else if (xfer_s) begin
      out_data_r  <= sel_data_s;
      out_valid_r <= 1'b1;
      out_chan_r  <= grant_idx_s;
      if (mode) begin
        rr_last_r <= grant_idx_s;
      end else begin
        rr_last_r <= rr_last_r;
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_chan  = out_chan_r;

endmodule
